// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type for the parity stream accumulator
package parity_pkg;
  typedef enum logic {ACC, FULL} state_e;
endpackage

// File: rtl/xor_reduce.sv
// xor_reduce: balanced combinational XOR tree over a WIDTH-bit word
//   in  [WIDTH-1:0]  word to reduce
//   out              XOR of all bits of in
module xor_reduce #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);
  localparam int LG = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int P = 1 << LG;
  // Heap-ordered tree: leaves at P..2P-1 (padded with zeros), root at 1.
  logic node [1:2*P-1];
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < WIDTH) begin : g_in
      assign node[P+i] = in[i];
    end else begin : g_pad
      assign node[P+i] = 1'b0;
    end
  end
  for (genvar i = 1; i < P; i++) begin : g_node
    assign node[i] = node[2*i] ^ node[2*i+1];
  end
  assign out = node[1];
endmodule

// File: rtl/parity_stream_acc.sv
// parity_stream_acc: folds word parity over a frame, emits parity + saturating beat count
//   in_valid/in_ready/in_data/in_last     input beat stream
//   out_valid/out_ready/out_parity/out_count  one result per frame
module parity_stream_acc
  import parity_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CW    = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CW-1:0]    out_count
);
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
  state_e          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_parity_q, out_parity_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            wp, take, fin;
  xor_reduce #(.WIDTH(WIDTH)) u_xor (.in(in_data), .out(wp));
  // A pending result only blocks input while the sink is stalling it.
  assign in_ready   = (state_q == ACC) | out_ready;
  assign out_valid  = state_q == FULL;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign take = in_valid & in_ready;
  assign fin  = take & in_last;
  always_comb begin
    acc_d        = fin ? 1'b0 : take ? acc_q ^ wp : acc_q;
    cnt_d        = fin ? '0 : take ? sat_inc(cnt_q) : cnt_q;
    out_parity_d = fin ? acc_q ^ wp ^ ODD : out_parity_q;
    out_count_d  = fin ? sat_inc(cnt_q) : out_count_q;
    state_d      = fin ? FULL : out_ready ? ACC : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
    end
  end
endmodule

// File: tb/tb_parity_stream_acc.sv
// tb_parity_stream_acc: scoreboard bench driving three parity_stream_acc configurations in lockstep
module tb_parity_stream_acc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       ir0, ir1, ir2, ov0, ov1, ov2, op0, op1, op2;
  logic [7:0] oc0, oc1;
  logic [1:0] oc2;
  int n_checks = 0;
  int n_fail = 0;
  logic [8:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  parity_stream_acc #(.WIDTH(5), .CW(8), .ODD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_parity(op0), .out_count(oc0));
  parity_stream_acc #(.WIDTH(5), .CW(8), .ODD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_parity(op1), .out_count(oc1));
  parity_stream_acc #(.WIDTH(5), .CW(2), .ODD(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_parity(op2), .out_count(oc2));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed frame result for the ODD=0/CW=8 view; the other views follow from it.
  task automatic push(input bit p, input int c);
    q0.push_back({p, 8'(c)});
    q1.push_back({~p, 8'(c)});
    q2.push_back({p, 8'(c > 3 ? 3 : c)});
  endtask

  task automatic send_beat(input logic [4:0] d, input logic l);
    logic r;
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      r = ir0;
      @(posedge clk);
      #1;
      t++;
    end while (!r && t < 50);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic idle_drain();
    int t;
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (ov0) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected0: got result expected none at %0t", $time);
        end else begin
          logic [8:0] e;
          e = q0.pop_front();
          chk("par_odd0", op0, e[8]);
          chk("cnt_cw8", oc0, e[7:0]);
        end
      end
      if (ov1) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected1: got result expected none at %0t", $time);
        end else begin
          logic [8:0] e;
          e = q1.pop_front();
          chk("par_odd1", op1, e[8]);
          chk("cnt_odd1", oc1, e[7:0]);
        end
      end
      if (ov2) begin
        if (q2.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected2: got result expected none at %0t", $time);
        end else begin
          logic [8:0] e;
          e = q2.pop_front();
          chk("par_cw2", op2, e[8]);
          chk("cnt_cw2", oc2, e[1:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && in_valid) assert (!$isunknown({in_data, in_last})) else $error("X on input beat");
    if (rst_n && ov0) assert (!$isunknown(out_ready)) else $error("X on out_ready");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ov0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ir0, 1);
    chk("rst_valid2", ov2, 0);
    chk("rst_par", op0, 0);
    chk("rst_cnt", oc0, 0);
    @(posedge clk);
    #1;
    // single beat 10110: 3 ones
    push(1'b1, 1);
    send_beat(5'b10110, 1'b1);
    chk("lat_valid", ov0, 1);
    chk("lat_par", op0, 1);
    chk("lat_par_odd", op1, 0);
    chk("lat_cnt", oc0, 1);
    idle_drain();
    // three-beat frame: 1+2+5 = 8 ones
    push(1'b0, 3);
    send_beat(5'b00001, 1'b0);
    send_beat(5'b00011, 1'b0);
    send_beat(5'b11111, 1'b1);
    idle_drain();
    // backpressure: pending 00111 (parity 1), waiting beat 00000 (parity 0)
    out_ready = 1'b0;
    push(1'b1, 1);
    send_beat(5'b00111, 1'b1);
    push(1'b0, 1);
    in_valid = 1'b1;
    in_data  = 5'b00000;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", ir0, 0);
      chk("bp_valid", ov0, 1);
      chk("bp_par", op0, 1);
      chk("bp_cnt", oc0, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_valid", ov0, 1);
    chk("bp_new_par", op0, 0);
    idle_drain();
    // back-to-back single-beat frames
    push(1'b1, 1);
    push(1'b0, 1);
    push(1'b1, 1);
    send_beat(5'b00001, 1'b1);
    chk("b2b_v1", ov0, 1);
    send_beat(5'b00000, 1'b1);
    chk("b2b_v2", ov0, 1);
    chk("b2b_p2", op0, 0);
    send_beat(5'b11111, 1'b1);
    chk("b2b_v3", ov0, 1);
    chk("b2b_p3", op0, 1);
    idle_drain();
    // five beats of 00001: parity 1, count 5 (3 when CW=2)
    push(1'b1, 5);
    for (int i = 0; i < 4; i++) send_beat(5'b00001, 1'b0);
    send_beat(5'b00001, 1'b1);
    chk("sat_cnt", oc2, 3);
    idle_drain();
    // reset after two beats of a frame discards it
    send_beat(5'b00001, 1'b0);
    send_beat(5'b00001, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_cnt", oc0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(1'b1, 1);
    send_beat(5'b00001, 1'b1);
    chk("post_rst_par", op0, 1);
    chk("post_rst_cnt", oc0, 1);
    idle_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_stream_acc.md
# parity_stream_acc

Streaming, parametrised parity accumulator: the sequential successor to the flat 5-input XOR benchmark. Accepts WIDTH-bit words over a valid/ready handshake, folds every bit of every word of a frame into one parity bit and emits one result per frame, together with a saturating beat count. Sits between a word-stream source and a checker or sink in the TOY benchmark set. With WIDTH=5 and single-beat frames it reproduces 5-input XOR (ODD=0) or XNOR (ODD=1).

## Interface
- WIDTH, 5, data word width in bits, ≥1
- CW, 8, beat-counter width in bits, ≥1
- ODD, 0, parity mode: 0 means result = XOR of all bits; 1 means result = inverted XOR
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept the input beat
- in_data  in  WIDTH  input word
- in_last  in  1  beat is the final beat of its frame
- out_valid  out  1  frame result valid
- out_ready  in  1  sink accepts the result
- out_parity  out  1  frame parity, per ODD
- out_count  out  CW  beats in the frame, saturating at 2^CW−1

## Operation
- Beat accepted on a rising edge with in_valid && in_ready. Frame result transferred on a rising edge with out_valid && out_ready.
- Word parity wp = XOR-reduce(in_data), purely combinational.
- Accumulator acc (1 bit) and counter cnt (CW bits) hold the state of the frame in progress.
- FSM has two states.
  - ACC: no result pending. out_valid=0, in_ready=1.
  - FULL: result pending. out_valid=1, in_ready=out_ready.
- Accepted non-last beat: acc ← acc ^ wp; cnt ← sat(cnt+1). State is unchanged.
- Accepted last beat:
  - out_parity ← acc ^ wp ^ ODD; out_count ← sat(cnt+1).
  - acc ← 0; cnt ← 0.
  - Next state = FULL.
- FULL with out_ready=1 and no last beat accepted: next state = ACC. Output registers hold their last values.
- FULL with out_ready=1 and a last beat accepted in the same cycle: old result drains and the new result loads. State stays FULL; out_valid stays 1.
- FULL with out_ready=0: in_ready=0. Nothing is accepted; outputs are stable.
- Saturation: sat(x) = min(x, 2^CW−1). The counter never wraps.
- Inputs are ignored when in_valid=0, including in_data and in_last.
- in_data, in_last and out_ready must not be X while the corresponding valid or FULL state is active. Assertions in the bench check this.

## Timing
- Reset (async assert, sync deassert by the environment) drives:
  - state=ACC, out_valid=0, out_parity=0, out_count=0, acc=0, cnt=0
  - in_ready=1 from the first cycle after deassert
- Latency: a last beat accepted at edge k gives out_valid=1 and valid out_parity/out_count from edge k until transfer.
- Throughput is one beat per cycle, including back-to-back single-beat frames while out_ready=1.
- in_ready depends combinationally on out_ready in FULL only. No other comb path runs from input to output.
- Reset mid-frame or with a result pending discards the partial frame and the pending result. No output is produced for them.
- out_valid never drops without a transfer, except on reset.

## Structure
- Package parity_pkg:
  - state enum state_e {ACC, FULL}
  - function sat_inc(cnt) parametrised by CW through a localparam, or instantiated in the module
- Sub-module xor_reduce #(WIDTH): in[WIDTH-1:0] → out. It is a balanced combinational XOR tree, reusable by other benchmarks.
- The top module contains the FSM, acc/cnt registers and output registers only.

## Test plan
- WIDTH=5, ODD=0, single beat 5'b10110 with last=1 → out_parity=1, out_count=1 one cycle later. Same stimulus with ODD=1 → out_parity=0.
- Three-beat frame 5'b00001, 5'b00011, 5'b11111 (last on beat 3), out_ready=1 → out_parity=0 (1+2+5=8 ones), out_count=3.
- Backpressure: result pending with out_ready=0 for 4 cycles while in_valid=1 → in_ready=0 and outputs stable throughout. Raising out_ready then transfers the result and accepts the waiting beat in the same cycle.
- Back-to-back single-beat frames 5'b00001, 5'b00000, 5'b11111 with out_ready=1 → out_valid held at 1 for 3 consecutive cycles, with parities 1, 0, 1.
- CW=2, frame of 5 beats of 5'b00001 → out_parity=1, out_count=3 (saturated).
- Assert rst_n mid-frame after 2 beats, then send a 1-beat frame 5'b00001 → out_parity=1, out_count=1. No residue from the aborted frame.
